if_fetch_unit: RTL
==================

// Module: if_fetch_unit
// PURPOSE
//  IF-stage producer for the IF/ID pipeline register: owns the PC, drives the imem address, presents
//  {pc,instr} plus the IF/ID write-enable and flush. Selects next PC (seq/branch/jump/eret/interrupt)
//  and runs the interrupt-entry FSM (EPC capture, vector, ISR masking until eret).
// PARAMETERS
//  RESET_PC    32'h0000_3000  PC after reset
//  INT_VECTOR  32'h0000_4180  interrupt handler entry address
// PORTS
//  clk            in   1   clock, all state on rising edge
//  rst_n          in   1   asynchronous, active-low reset
//  stall          in   1   hazard stall from ID; 1 = hold PC and IF/ID contents
//  br_taken       in   1   branch resolved taken in ID
//  br_target      in   32  branch target
//  jmp            in   1   jump in ID
//  jmp_target     in   32  jump target
//  eret           in   1   eret in ID
//  epc_in         in   32  EPC from CP0 (return address for eret)
//  int_req        in   1   external interrupt, level-sensitive
//  int_en         in   1   global interrupt enable (CP0 status IE)
//  imem_addr      out  32  instruction memory address (= pc)
//  imem_rdata     in   32  instruction word, combinational from imem_addr
//  ifid_pc        out  32  PC to IF/ID
//  ifid_instr     out  32  instruction to IF/ID
//  ifid_we        out  1   IF/ID write enable (= ~stall)
//  ifid_flush     out  1   IF/ID synchronous clear, active-high
//  epc_we         out  1   one-cycle strobe: write epc_out into CP0 EPC
//  epc_out        out  32  return address for interrupted flow
//  in_isr         out  1   1 while handler runs; masks new interrupts
// BEHAVIOUR
//  - Reset: pc=RESET_PC, state=RUN, pend=0, in_isr=0; comb outputs settle to epc_we=0, ifid_flush=0.
//  - pc register; imem_addr=ifid_pc=pc, ifid_instr=imem_rdata, ifid_we=~stall (all combinational).
//  - Next PC priority, applied only on edges where stall=0:
//    take_int > eret > jmp > br_taken > pc+4. pc+4 wraps mod 2^32 (32'hFFFF_FFFC -> 0).
//  - Redirect = take_int|eret|jmp|br_taken. ifid_flush=redirect&~stall, combinational, so IF/ID
//    clears on the same edge the PC changes (no delay slot; fetched wrong-path word is squashed).
//  - While stall=1: PC, FSM and pend hold; no flush, no epc_we; redirect inputs ignored
//    (ID holds them stable until stall drops).
//  - pend: set on edge when irq & int_en & state==RUN; cleared on entry; cleared if int_en drops
//    before entry. irq = int_req (or synchronized copy, see CONFIGURATION).
//  - FSM states:
//    RUN : take_int = pend & ~stall. On take_int: pc<=INT_VECTOR, epc_we=1 for that cycle,
//          epc_out = br_target if br_taken, jmp_target if jmp, epc_in if eret, else pc; -> ISR.
//    ISR : in_isr=1; pend cannot set; eret&~stall -> pc<=epc_in, flush, -> RUN.
//    eret in RUN: pc<=epc_in, flush, state stays RUN (spurious eret legal).
//  - epc_out = pc (combinational) when epc_we=0.
//  - Interrupt simultaneous with branch/jump/eret: interrupt wins; the redirect target becomes EPC
//    so the redirect is not lost.
//  - int_req pulse shorter than one cycle while int_en=1 may be missed (level protocol).
//  - Latency: irq high at edge N sets pend; vector fetched in cycle N+1 if stall=0.
//  - Async reset mid-ISR: returns to RUN at RESET_PC, pend cleared.
// CONFIGURATION
//  FETCH_IRQ_SYNC_EN: defined -> int_req passes 2-flop synchronizer (reset 0) before pend logic;
//   entry latency +2 cycles. Undefined -> int_req used directly (same clock domain).
// TESTING
//  1 reset release, stall=0, no events -> ifid_pc 0x3000,0x3004,0x3008 on successive cycles.
//  2 stall=1 for 3 cycles at pc=0x3008 -> pc, ifid_we=0 held; stall=0 -> 0x300C next.
//  3 br_taken=1, br_target=0x3100 at pc=0x3010 -> ifid_flush=1 that cycle; next pc=0x3100.
//  4 int_en=1, int_req=1 at pc=0x3020 -> pend; next cycle epc_we=1, epc_out=0x3024 (pc),
//    flush, pc=0x4180, in_isr=1; second int_req ignored while in_isr.
//  5 int taken same cycle as jmp to 0x3200 -> epc_out=0x3200, pc=0x4180; later eret with
//    epc_in=0x3200 -> pc=0x3200, in_isr=0, flush pulse.
//  6 stall=1 with pend=1 -> no entry until stall=0; rst_n low mid-ISR -> pc=0x3000, in_isr=0.

Source files
------------

// File: rtl/if_fetch_unit.sv
// IF-stage producer: owns the PC, selects the next fetch address and runs interrupt entry/exit.
// Optional macro FETCH_IRQ_SYNC_EN inserts a 2-flop synchronizer on int_req.
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_3000,
    parameter logic [31:0] INT_VECTOR = 32'h0000_4180
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        br_taken,
    input  logic [31:0] br_target,
    input  logic        jmp,
    input  logic [31:0] jmp_target,
    input  logic        eret,
    input  logic [31:0] epc_in,
    input  logic        int_req,
    input  logic        int_en,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    output logic [31:0] ifid_pc,
    output logic [31:0] ifid_instr,
    output logic        ifid_we,
    output logic        ifid_flush,
    output logic        epc_we,
    output logic [31:0] epc_out,
    output logic        in_isr
);

    typedef enum logic [0:0] {
        StRun,
        StIsr
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        pend_q, pend_d;
    logic        irq;

    logic        take_int;
    logic        flow_redirect;
    logic [31:0] flow_target;
    logic [31:0] pc_seq;

`ifdef FETCH_IRQ_SYNC_EN
    logic [1:0] irq_sync_q, irq_sync_d;

    assign irq_sync_d = {irq_sync_q[0], int_req};
    assign irq        = irq_sync_q[1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            irq_sync_q <= 2'b00;
        end else begin
            irq_sync_q <= irq_sync_d;
        end
    end
`else
    assign irq = int_req;
`endif

    assign pc_seq        = pc_q + 32'd4;
    assign take_int      = pend_q & ~stall & (state_q == StRun);
    assign flow_redirect = eret | jmp | br_taken;

    always_comb begin
        if (eret) begin
            flow_target = epc_in;
        end else if (jmp) begin
            flow_target = jmp_target;
        end else if (br_taken) begin
            flow_target = br_target;
        end else begin
            flow_target = pc_seq;
        end
    end

    always_comb begin
        pc_d    = pc_q;
        state_d = state_q;
        pend_d  = pend_q;
        if (!stall) begin
            if (take_int) begin
                pc_d    = INT_VECTOR;
                state_d = StIsr;
                pend_d  = 1'b0;
            end else begin
                pc_d = flow_target;
                if (eret) begin
                    state_d = StRun;
                end
                // Dropping int_en before entry cancels a pending request.
                pend_d = int_en & (pend_q | (irq & (state_q == StRun)));
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q    <= RESET_PC;
            state_q <= StRun;
            pend_q  <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            state_q <= state_d;
            pend_q  <= pend_d;
        end
    end

    assign imem_addr  = pc_q;
    assign ifid_pc    = pc_q;
    assign ifid_instr = imem_rdata;
    assign ifid_we    = ~stall;
    assign ifid_flush = (take_int | flow_redirect) & ~stall;
    assign epc_we     = take_int;
    assign in_isr     = (state_q == StIsr);

    // A redirect coinciding with interrupt entry becomes the return address.
    assign epc_out = (take_int & flow_redirect) ? flow_target : pc_q;

endmodule
